// File: rtl/mult_div_unit.sv
// ============================================================================
// Module      : mult_div_unit
// Description : Iterative MIPS multiply/divide unit owning the HI/LO registers.
//               Optional single-cycle multiply when MULT_DIV_FAST_MULT_EN is
//               defined (divide stays iterative).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mult_div_unit #(
  parameter int CYCLES = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        mthi,
  input  logic        mtlo,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [5:0] LAST_STEP = 6'(CYCLES - 1);

  state_t      state_q;
  logic [5:0]  cnt_q;
  logic        is_div_q;
  logic        neg_q;
  logic        rneg_q;
  logic [31:0] opnd_q;
  logic [63:0] acc_q;
  logic [31:0] hi_q;
  logic [31:0] lo_q;
  logic        busy_q;
  logic        done_q;

  // Operand conditioning at issue
  logic        sgn_d;
  logic        dz_d;
  logic [31:0] a_abs_d;
  logic [31:0] b_abs_d;
  logic        neg_d;
  logic        rneg_d;

  always_comb begin
    sgn_d   = ~op[0];
    dz_d    = op[1] && (b == 32'd0);
    a_abs_d = (sgn_d && a[31]) ? (~a + 32'd1) : a;
    b_abs_d = (sgn_d && b[31]) ? (~b + 32'd1) : b;
    // A zero divisor must leave the all-ones quotient un-negated.
    neg_d   = sgn_d && (a[31] ^ b[31]) && !dz_d;
    rneg_d  = sgn_d && op[1] && a[31];
  end

  // One iteration of shift-add or restoring division
  logic [32:0] mul_sum;
  logic [63:0] mul_next;
  logic [32:0] div_r;
  logic        div_ge;
  logic [31:0] div_sub;
  logic [63:0] div_next;
  logic [63:0] acc_d;

  always_comb begin
    mul_sum  = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opnd_q} : 33'd0);
    mul_next = {mul_sum, acc_q[31:1]};
    div_r    = acc_q[63:31];
    div_ge   = (div_r >= {1'b0, opnd_q});
    // When the subtraction is taken the true result is below the divisor, so 32 bits suffice.
    div_sub  = div_r[31:0] - opnd_q;
    div_next = {(div_ge ? div_sub : div_r[31:0]), acc_q[30:0], div_ge};
    acc_d    = is_div_q ? div_next : mul_next;
  end

  // Sign correction on the final iteration
  logic [63:0] prod_fix;
  logic [31:0] quo_fix;
  logic [31:0] rem_fix;
  logic [31:0] res_hi;
  logic [31:0] res_lo;

  always_comb begin
    prod_fix = neg_q  ? (~acc_d + 64'd1)        : acc_d;
    quo_fix  = neg_q  ? (~acc_d[31:0] + 32'd1)  : acc_d[31:0];
    rem_fix  = rneg_q ? (~acc_d[63:32] + 32'd1) : acc_d[63:32];
    res_hi   = is_div_q ? rem_fix : prod_fix[63:32];
    res_lo   = is_div_q ? quo_fix : prod_fix[31:0];
  end

`ifdef MULT_DIV_FAST_MULT_EN
  logic [63:0] fast_prod;

  always_comb begin
    fast_prod = {{32{sgn_d & a[31]}}, a} * {{32{sgn_d & b[31]}}, b};
  end
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= 6'd0;
      is_div_q <= 1'b0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      opnd_q   <= 32'd0;
      acc_q    <= 64'd0;
      hi_q     <= 32'd0;
      lo_q     <= 32'd0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
`ifdef MULT_DIV_FAST_MULT_EN
            if (!op[1]) begin
              hi_q    <= fast_prod[63:32];
              lo_q    <= fast_prod[31:0];
              state_q <= S_DONE;
              busy_q  <= 1'b1;
              done_q  <= 1'b1;
            end else
`endif
            begin
              is_div_q <= op[1];
              neg_q    <= neg_d;
              rneg_q   <= rneg_d;
              opnd_q   <= op[1] ? b_abs_d : a_abs_d;
              acc_q    <= {32'd0, (op[1] ? a_abs_d : b_abs_d)};
              cnt_q    <= 6'd0;
              state_q  <= S_RUN;
              busy_q   <= 1'b1;
            end
          end else begin
            if (mthi) hi_q <= a;
            if (mtlo) lo_q <= a;
          end
        end
        S_RUN: begin
          acc_q <= acc_d;
          cnt_q <= cnt_q + 6'd1;
          if (cnt_q == LAST_STEP) begin
            hi_q    <= res_hi;
            lo_q    <= res_lo;
            state_q <= S_DONE;
            done_q  <= 1'b1;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

`default_nettype wire

// File: tb/tb_mult_div_unit.sv
// ============================================================================
// Module      : tb_mult_div_unit
// Description : Directed scoreboard bench for mult_div_unit (honours
//               MULT_DIV_FAST_MULT_EN for multiply latency).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mult_div_unit;

  logic        clk;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        mthi;
  logic        mtlo;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  logic [63:0] sb_q[$];

`ifdef MULT_DIV_FAST_MULT_EN
  localparam int MUL_LAT = 0;
`else
  localparam int MUL_LAT = 32;
`endif
  localparam int DIV_LAT = 32;

  mult_div_unit #(.CYCLES(32)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .mthi  (mthi),
    .mtlo  (mtlo),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    cyc++;
  endtask

  // Drive one issue; the expected {hi,lo} goes onto the scoreboard.
  task automatic issue(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                       input logic [63:0] exp);
    op    = o;
    a     = x;
    b     = y;
    start = 1'b1;
    sb_q.push_back(exp);
    @(negedge clk);
    cyc   = 0;
    start = 1'b0;
    a     = $urandom;
    b     = $urandom;
  endtask

  task automatic wait_done(input string tag, input int exp_lat);
    logic [63:0] exp;
    while (done !== 1'b1 && cyc < 100) tick();
    chk({tag, "_latency"}, 64'(cyc), 64'(exp_lat));
    exp = (sb_q.size() > 0) ? sb_q.pop_front() : 64'hx;
    chk({tag, "_hi"}, {32'd0, hi}, {32'd0, exp[63:32]});
    chk({tag, "_lo"}, {32'd0, lo}, {32'd0, exp[31:0]});
    chk({tag, "_busy_at_done"}, {63'd0, busy}, 64'd1);
    tick();
    chk({tag, "_done_pulse"}, {63'd0, done}, 64'd0);
    chk({tag, "_idle"}, {63'd0, busy}, 64'd0);
  endtask

  initial begin
    logic seen_done;
    reset = 1'b0;
    start = 1'b0;
    op    = 2'b00;
    a     = 32'd0;
    b     = 32'd0;
    mthi  = 1'b0;
    mtlo  = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    tick();
    chk("reset_hi", {32'd0, hi}, 64'd0);
    chk("reset_lo", {32'd0, lo}, 64'd0);
    chk("reset_busy", {63'd0, busy}, 64'd0);
    chk("reset_done", {63'd0, done}, 64'd0);

    // Direct HI/LO writes
    a = 32'h12345678; mtlo = 1'b1;
    tick();
    mtlo = 1'b0;
    chk("mtlo_lo", {32'd0, lo}, 64'h12345678);
    chk("mtlo_hi_kept", {32'd0, hi}, 64'd0);
    a = 32'hCAFEF00D; mthi = 1'b1;
    tick();
    mthi = 1'b0;
    chk("mthi", {hi, lo}, 64'hCAFEF00D_12345678);
    a = 32'h0BADF00D; mthi = 1'b1; mtlo = 1'b1;
    tick();
    mthi = 1'b0; mtlo = 1'b0;
    chk("mthi_mtlo", {hi, lo}, 64'h0BADF00D_0BADF00D);

    // start has priority over mthi
    mthi = 1'b1;
    issue(2'b01, 32'd3, 32'd5, 64'h00000000_0000000F);
    mthi = 1'b0;
    chk("issue_busy", {63'd0, busy}, 64'd1);
    wait_done("multu_prio", MUL_LAT);

    issue(2'b00, 32'hFFFFFFFE, 32'h00000003, 64'hFFFFFFFF_FFFFFFFA);
    wait_done("mult_neg", MUL_LAT);
    issue(2'b01, 32'hFFFFFFFE, 32'h00000003, 64'h00000002_FFFFFFFA);
    wait_done("multu", MUL_LAT);
    issue(2'b00, 32'h80000000, 32'h80000000, 64'h40000000_00000000);
    wait_done("mult_minmin", MUL_LAT);

    issue(2'b10, 32'hFFFFFFF9, 32'd2, 64'hFFFFFFFF_FFFFFFFD);
    chk("div_no_early_done", {63'd0, done}, 64'd0);
    wait_done("div_neg", DIV_LAT);
    issue(2'b11, 32'd7, 32'd2, 64'h00000001_00000003);
    wait_done("divu", DIV_LAT);
    issue(2'b10, 32'd7, 32'hFFFFFFFE, 64'h00000001_FFFFFFFD);
    wait_done("div_negdiv", DIV_LAT);
    issue(2'b11, 32'h55, 32'd0, 64'h00000055_FFFFFFFF);
    wait_done("divu_by0", DIV_LAT);
    issue(2'b10, 32'hFFFFFFF9, 32'd0, 64'hFFFFFFF9_FFFFFFFF);
    wait_done("div_by0", DIV_LAT);
    issue(2'b10, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000);
    wait_done("div_ovf", DIV_LAT);

    // start and mthi during RUN are ignored
    issue(2'b11, 32'd100, 32'd7, 64'h00000002_0000000E);
    repeat (5) tick();
    start = 1'b1; op = 2'b11; mthi = 1'b1; a = 32'hDEADBEEF; b = 32'd1;
    tick();
    start = 1'b0; mthi = 1'b0;
    wait_done("run_ignore", DIV_LAT);

    // Reset in the middle of an operation aborts it
    issue(2'b11, 32'h1000, 32'd3, 64'd0);
    repeat (9) tick();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    sb_q.delete();
    chk("abort_busy", {63'd0, busy}, 64'd0);
    chk("abort_hilo", {hi, lo}, 64'd0);
    seen_done = 1'b0;
    repeat (40) begin
      tick();
      if (done === 1'b1) seen_done = 1'b1;
    end
    chk("abort_no_done", {63'd0, seen_done}, 64'd0);
    chk("abort_hilo_kept", {hi, lo}, 64'd0);

    issue(2'b01, 32'h00010000, 32'h00010000, 64'h00000001_00000000);
    wait_done("multu_wide", MUL_LAT);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
